// File: rtl/mic_level_meter_if.sv
// Sample stream in, level / thermometer code / update pulse out for the mic level meter.
interface mic_level_meter_if;
    logic        sample_valid;
    logic [11:0] sample;
    logic [4:0]  level;
    logic [15:0] level_code;
    logic        window_done;

    modport master (output sample_valid, sample, input level, level_code, window_done);
    modport slave  (input sample_valid, sample, output level, level_code, window_done);
endinterface

// File: rtl/mic_level_meter.sv
// Windowed peak meter: |sample-MID| peak per window, quantised to 0..16 steps plus thermometer code.
// Optional macro LEVEL_DECAY_EN: a falling level drops at most one step per window.
module mic_level_meter #(
    parameter int WINDOW_SAMPLES = 4000,
    parameter int MID            = 2048,
    parameter int STEP           = 120
) (
    input  logic              clock,
    input  logic              resetn,
    mic_level_meter_if.slave  mif
);
    localparam logic [12:0] MID13 = 13'(MID);
    localparam logic [15:0] LAST  = 16'(WINDOW_SAMPLES - 1);

    logic [15:0] cnt;
    logic [12:0] peak, hold, smp13, mag, peak_nxt;
    logic        pend;
    logic [4:0]  lvl_q, newlvl, lvl_nxt;
    logic [15:0] code_q, code_nxt;
    logic        done_q;

    // 13-bit compare keeps the full 0..2048 magnitude range without wrapping
    always_comb begin
        smp13    = {1'b0, mif.sample};
        mag      = (smp13 >= MID13) ? (smp13 - MID13) : (MID13 - smp13);
        peak_nxt = (mag > peak) ? mag : peak;
    end

    // Threshold ladder instead of a divider; thresholds are monotonic so the last hit wins
    always_comb begin
        newlvl = '0;
        for (int k = 1; k <= 16; k++)
            if ({19'd0, hold} >= 32'(k * STEP)) newlvl = 5'(k);
    end

    always_comb begin
`ifdef LEVEL_DECAY_EN
        lvl_nxt = (newlvl >= lvl_q) ? newlvl : (lvl_q - 5'd1);
`else
        lvl_nxt = newlvl;
`endif
        code_nxt = '0;
        for (int i = 0; i < 16; i++)
            code_nxt[i] = (5'(i) < lvl_nxt);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt    <= '0;
            peak   <= '0;
            hold   <= '0;
            pend   <= 1'b0;
            lvl_q  <= '0;
            code_q <= '0;
            done_q <= 1'b0;
        end else begin
            pend   <= 1'b0;
            done_q <= 1'b0;
            if (mif.sample_valid) begin
                if (cnt == LAST) begin
                    hold <= peak_nxt;
                    peak <= '0;
                    cnt  <= '0;
                    pend <= 1'b1;
                end else begin
                    peak <= peak_nxt;
                    cnt  <= cnt + 16'd1;
                end
            end
            // Update lands one edge after the window closes, from the captured hold
            if (pend) begin
                lvl_q  <= lvl_nxt;
                code_q <= code_nxt;
                done_q <= 1'b1;
            end
        end
    end

    assign mif.level       = lvl_q;
    assign mif.level_code  = code_q;
    assign mif.window_done = done_q;
endmodule
